pattern_gen_video: RTL and testbench

//  Parametrised successor to the fixed 640x480 square demo: integrated timing generator plus
//  run-time selectable test patterns (static square, colour bars, checkerboard, bouncing square).

---
 rtl/video_pkg.sv | 29 ++
 rtl/video_timing.sv | 62 ++++++
 rtl/pattern_gen_video.sv | 154 +++++++++++++++
 tb/tb_pattern_gen_video.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared types and colour constants for the video pattern generator
// Contents: pattern_e (mode encoding), rgb_t (one nibble per channel), bar colour table.
package video_pkg;

    typedef enum logic [1:0] {
        PAT_SQUARE = 2'd0,
        PAT_BARS   = 2'd1,
        PAT_CHECK  = 2'd2,
        PAT_BOUNCE = 2'd3
    } pattern_e;

    // Colours are chosen at nibble precision and replicated up to BPC at the output.
    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    localparam rgb_t NIB_WHITE = 12'hFFF;
    localparam rgb_t NIB_BG    = 12'h137;
    localparam rgb_t NIB_BLACK = 12'h000;

    // Bar colours as {r,g,b} on/off bits; element 0 is the leftmost bar.
    // Order: white, yellow, cyan, green, magenta, red, blue, black.
    localparam logic [7:0][2:0] BAR_RGB = {
        3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
    };

endpackage

// File: rtl/video_timing.sv
// rtl/video_timing.sv - raster counters, syncs, data enable and end-of-frame flag
// Ports: clk_pix/rst_pix (async active-high reset); cx, cy raster position;
//        hsync_c, vsync_c, de_c, frame_c combinational flags for the current (cx,cy).
module video_timing #(
    parameter int   CORDW    = 10,
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic             clk_pix,
    input  logic             rst_pix,
    output logic [CORDW-1:0] cx,
    output logic [CORDW-1:0] cy,
    output logic             hsync_c,
    output logic             vsync_c,
    output logic             de_c,
    output logic             frame_c
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CORDW-1:0] ONE    = CORDW'(1);
    localparam logic [CORDW-1:0] H_LAST = CORDW'(H_TOTAL - 1);
    localparam logic [CORDW-1:0] V_LAST = CORDW'(V_TOTAL - 1);
    localparam logic [CORDW-1:0] H_ACT  = CORDW'(H_ACTIVE);
    localparam logic [CORDW-1:0] V_ACT  = CORDW'(V_ACTIVE);
    localparam logic [CORDW-1:0] HS_BEG = CORDW'(H_ACTIVE + H_FP);
    localparam logic [CORDW-1:0] VS_BEG = CORDW'(V_ACTIVE + V_FP);
    // Sync end may equal 2**CORDW when the back porch is zero, hence the extra bit.
    localparam logic [CORDW:0]   HS_END = (CORDW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CORDW:0]   VS_END = (CORDW+1)'(V_ACTIVE + V_FP + V_SYNC);

    logic hs_act;
    logic vs_act;

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            cx <= '0;
            cy <= '0;
        end else if (cx == H_LAST) begin
            cx <= '0;
            cy <= (cy == V_LAST) ? '0 : cy + ONE;
        end else begin
            cx <= cx + ONE;
        end
    end

    assign hs_act  = (cx >= HS_BEG) && ({1'b0, cx} < HS_END);
    assign vs_act  = (cy >= VS_BEG) && ({1'b0, cy} < VS_END);
    assign hsync_c = hs_act ? SYNC_POL : ~SYNC_POL;
    assign vsync_c = vs_act ? SYNC_POL : ~SYNC_POL;
    assign de_c    = (cx < H_ACT) && (cy < V_ACT);
    assign frame_c = (cx == H_LAST) && (cy == V_LAST);

endmodule

// File: rtl/pattern_gen_video.sv
// rtl/pattern_gen_video.sv - timing generator plus selectable test patterns, registered outputs
// Ports: clk_pix, rst_pix (async active-high); mode (0 square, 1 bars, 2 checker, 3 bounce);
//        sx, sy, hsync, vsync, de, frame, r, g, b all registered one clock after the raster counters.
module pattern_gen_video #(
    parameter int   CORDW    = 10,
    parameter int   BPC      = 8,
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0,
    parameter int   SQ_SIZE  = 200,
    parameter int   CHK_LOG2 = 5
) (
    input  logic             clk_pix,
    input  logic             rst_pix,
    input  logic [1:0]       mode,
    output logic [CORDW-1:0] sx,
    output logic [CORDW-1:0] sy,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic             frame,
    output logic [BPC-1:0]   r,
    output logic [BPC-1:0]   g,
    output logic [BPC-1:0]   b
);
    import video_pkg::*;

    localparam logic [CORDW-1:0] ONE    = CORDW'(1);
    localparam logic [CORDW-1:0] SQ_X0  = CORDW'((H_ACTIVE - SQ_SIZE) / 2);
    localparam logic [CORDW-1:0] SQ_Y0  = CORDW'((V_ACTIVE - SQ_SIZE) / 2);
    localparam logic [CORDW-1:0] BX_MAX = CORDW'(H_ACTIVE - SQ_SIZE);
    localparam logic [CORDW-1:0] BY_MAX = CORDW'(V_ACTIVE - SQ_SIZE);
    localparam logic [CORDW:0]   SQ_W   = (CORDW+1)'(SQ_SIZE);
    localparam logic [CORDW-1:0] BAR_W  = CORDW'(H_ACTIVE / 8);
    localparam logic [CORDW-1:0] BAR_LAST = CORDW'(7);

    logic [CORDW-1:0] cx, cy;
    logic             hsync_c, vsync_c, de_c, frame_c;

    video_timing #(
        .CORDW    (CORDW),
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
        .SYNC_POL (SYNC_POL)
    ) u_timing (
        .clk_pix (clk_pix),
        .rst_pix (rst_pix),
        .cx      (cx),
        .cy      (cy),
        .hsync_c (hsync_c),
        .vsync_c (vsync_c),
        .de_c    (de_c),
        .frame_c (frame_c)
    );

    pattern_e         mode_q;
    logic [CORDW-1:0] bx, by;
    logic             dx_neg, dy_neg;

    // Mode and bounce position only move at the frame boundary so a frame never tears.
    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            mode_q <= PAT_SQUARE;
            bx     <= '0;
            by     <= '0;
            dx_neg <= 1'b0;
            dy_neg <= 1'b0;
        end else if (frame_c) begin
            mode_q <= pattern_e'(mode);

            if (!dx_neg && bx == BX_MAX) begin
                dx_neg <= 1'b1;
                bx     <= bx - ONE;
            end else if (dx_neg && bx == '0) begin
                dx_neg <= 1'b0;
                bx     <= bx + ONE;
            end else begin
                bx <= dx_neg ? bx - ONE : bx + ONE;
            end

            if (!dy_neg && by == BY_MAX) begin
                dy_neg <= 1'b1;
                by     <= by - ONE;
            end else if (dy_neg && by == '0) begin
                dy_neg <= 1'b0;
                by     <= by + ONE;
            end else begin
                by <= dy_neg ? by - ONE : by + ONE;
            end
        end
    end

    logic [CORDW-1:0] sq_x, sq_y;
    logic             in_sq;
    logic [CORDW-1:0] bar_pos;
    logic [2:0]       bar_idx;
    logic [2:0]       bar_bits;
    rgb_t             nib;

    always_comb begin
        nib      = NIB_BLACK;
        sq_x     = (mode_q == PAT_BOUNCE) ? bx : SQ_X0;
        sq_y     = (mode_q == PAT_BOUNCE) ? by : SQ_Y0;
        // One extra bit so the far edge of the square cannot wrap.
        in_sq    = ({1'b0, cx} >= {1'b0, sq_x}) && ({1'b0, cx} < ({1'b0, sq_x} + SQ_W)) &&
                   ({1'b0, cy} >= {1'b0, sq_y}) && ({1'b0, cy} < ({1'b0, sq_y} + SQ_W));
        bar_pos  = cx / BAR_W;
        // Pixels past the eighth bar (H_ACTIVE not a multiple of 8) stay black.
        bar_idx  = (bar_pos > BAR_LAST) ? 3'd7 : bar_pos[2:0];
        bar_bits = BAR_RGB[bar_idx];

        case (mode_q)
            PAT_SQUARE, PAT_BOUNCE: nib = in_sq ? NIB_WHITE : NIB_BG;
            PAT_BARS:  nib = {{4{bar_bits[2]}}, {4{bar_bits[1]}}, {4{bar_bits[0]}}};
            PAT_CHECK: nib = (cx[CHK_LOG2] ^ cy[CHK_LOG2]) ? NIB_WHITE : NIB_BLACK;
            default:   nib = NIB_BLACK;
        endcase

        if (!de_c) begin
            nib = NIB_BLACK;
        end
    end

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            sx    <= '0;
            sy    <= '0;
            hsync <= ~SYNC_POL;
            vsync <= ~SYNC_POL;
            de    <= 1'b0;
            frame <= 1'b0;
            r     <= '0;
            g     <= '0;
            b     <= '0;
        end else begin
            sx    <= cx;
            sy    <= cy;
            hsync <= hsync_c;
            vsync <= vsync_c;
            de    <= de_c;
            frame <= frame_c;
            r     <= {(BPC/4){nib.r}};
            g     <= {(BPC/4){nib.g}};
            b     <= {(BPC/4){nib.b}};
        end
    end

endmodule

// File: tb/tb_pattern_gen_video.sv
// tb/tb_pattern_gen_video.sv - directed self-checking bench for pattern_gen_video on a reduced raster
module tb_pattern_gen_video;

    // Reduced raster keeps whole frames short: 44 x 28 = 1232 clocks per frame.
    localparam int CORDW    = 6;
    localparam int BPC      = 8;
    localparam int H_ACTIVE = 36;
    localparam int H_FP     = 2;
    localparam int H_SYNC   = 4;
    localparam int H_BP     = 2;
    localparam int V_ACTIVE = 24;
    localparam int V_FP     = 1;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 1;
    localparam int SQ_SIZE  = 20;
    localparam int CHK_LOG2 = 2;

    localparam logic [23:0] C_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] C_BG      = 24'h113377;
    localparam logic [23:0] C_BLACK   = 24'h000000;
    localparam logic [23:0] C_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] C_CYAN    = 24'h00FFFF;
    localparam logic [23:0] C_RED     = 24'hFF0000;
    localparam logic [23:0] C_BLUE    = 24'h0000FF;

    logic             clk_pix = 1'b0;
    logic             rst_pix = 1'b1;
    logic [1:0]       mode    = 2'd0;
    logic [CORDW-1:0] sx, sy;
    logic             hsync, vsync, de, frame;
    logic [BPC-1:0]   r, g, b;
    logic [23:0]      rgb;

    int n_cmp = 0;
    int n_bad = 0;
    int frames = 0;

    assign rgb = {r, g, b};

    pattern_gen_video #(
        .CORDW (CORDW), .BPC (BPC),
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
        .SYNC_POL (1'b0), .SQ_SIZE (SQ_SIZE), .CHK_LOG2 (CHK_LOG2)
    ) dut (
        .clk_pix (clk_pix),
        .rst_pix (rst_pix),
        .mode    (mode),
        .sx      (sx),
        .sy      (sy),
        .hsync   (hsync),
        .vsync   (vsync),
        .de      (de),
        .frame   (frame),
        .r       (r),
        .g       (g),
        .b       (b)
    );

    always #5 clk_pix = ~clk_pix;

    // Frame pulses seen since the last reset; read in the bench only between edges.
    always @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix)    frames <= 0;
        else if (frame) frames <= frames + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_pix(input string tag, input int x, input int y);
        int n = 0;
        do begin
            @(negedge clk_pix);
            n++;
        end while (!(int'(sx) == x && int'(sy) == y) && n < 3000);
        check({tag, "_reached"}, {26'd0, sx}, 32'(x));
    endtask

    task automatic wait_frame(input string tag);
        int n = 0;
        do begin
            @(negedge clk_pix);
            n++;
        end while (frame !== 1'b1 && n < 3000);
        check({tag, "_frame"}, {31'd0, frame}, 32'd1);
    endtask

    // Reference bounce: position shown in the frame after n frame boundaries.
    function automatic int bounce_pos(input int n, input int maxp);
        int p = 0;
        int d = 1;
        for (int i = 0; i < n; i++) begin
            if (d == 1 && p == maxp) begin
                d = -1;
                p = p - 1;
            end else if (d == -1 && p == 0) begin
                d = 1;
                p = p + 1;
            end else begin
                p = p + d;
            end
        end
        return p;
    endfunction

    initial begin
        int cnt, de_n, hs_n, vs_n, k, fx, fy;
        bit found;

        // Reset state
        repeat (3) @(negedge clk_pix);
        check("rst_sx", {26'd0, sx}, 32'd0);
        check("rst_sy", {26'd0, sy}, 32'd0);
        check("rst_de", {31'd0, de}, 32'd0);
        check("rst_frame", {31'd0, frame}, 32'd0);
        check("rst_hsync", {31'd0, hsync}, 32'd1);
        check("rst_vsync", {31'd0, vsync}, 32'd1);
        check("rst_rgb", {8'd0, rgb}, 32'd0);

        rst_pix = 1'b0;
        @(negedge clk_pix);
        check("first_sx", {26'd0, sx}, 32'd0);
        check("first_sy", {26'd0, sy}, 32'd0);
        check("first_de", {31'd0, de}, 32'd1);
        check("first_rgb", {8'd0, rgb}, {8'd0, C_BG});
        @(negedge clk_pix);
        check("second_sx", {26'd0, sx}, 32'd1);

        // Timing over one whole frame
        wait_frame("t1a");
        check("frame_at_sx", {26'd0, sx}, 32'd43);
        check("frame_at_sy", {26'd0, sy}, 32'd27);
        cnt = 0; de_n = 0; hs_n = 0; vs_n = 0;
        do begin
            @(negedge clk_pix);
            cnt++;
            if (de)     de_n++;
            if (!hsync) hs_n++;
            if (!vsync) vs_n++;
        end while (frame !== 1'b1 && cnt < 3000);
        check("frame_period", 32'(cnt), 32'd1232);
        check("de_count", 32'(de_n), 32'd864);
        check("hsync_low_count", 32'(hs_n), 32'd112);
        check("vsync_low_count", 32'(vs_n), 32'd88);

        wait_pix("hs37", 37, 0);
        check("hsync_37", {31'd0, hsync}, 32'd1);
        @(negedge clk_pix);
        check("hsync_38", {31'd0, hsync}, 32'd0);
        wait_pix("hs41", 41, 0);
        check("hsync_41", {31'd0, hsync}, 32'd0);
        @(negedge clk_pix);
        check("hsync_42", {31'd0, hsync}, 32'd1);
        wait_pix("vs24", 43, 24);
        check("vsync_l24", {31'd0, vsync}, 32'd1);
        wait_pix("vs25", 0, 25);
        check("vsync_l25", {31'd0, vsync}, 32'd0);
        wait_pix("vs26", 43, 26);
        check("vsync_l26", {31'd0, vsync}, 32'd0);
        wait_pix("vs27", 0, 27);
        check("vsync_l27", {31'd0, vsync}, 32'd1);

        // Static square: qx = 8, qy = 2, edge 20
        wait_pix("sq_tl", 8, 2);
        check("sq_top_left", {8'd0, rgb}, {8'd0, C_WHITE});
        wait_pix("sq_l", 7, 3);
        check("sq_left_out", {8'd0, rgb}, {8'd0, C_BG});
        wait_pix("sq_br", 27, 21);
        check("sq_bottom_right", {8'd0, rgb}, {8'd0, C_WHITE});
        @(negedge clk_pix);
        check("sq_right_out", {8'd0, rgb}, {8'd0, C_BG});
        wait_pix("sq_b", 8, 22);
        check("sq_below_out", {8'd0, rgb}, {8'd0, C_BG});

        // Colour bars, 4 pixels each; 32..35 saturate to black
        mode = 2'd1;
        wait_frame("t3");
        wait_pix("bar0", 0, 5);
        check("bar_white", {8'd0, rgb}, {8'd0, C_WHITE});
        wait_pix("bar0e", 3, 5);
        check("bar_white_end", {8'd0, rgb}, {8'd0, C_WHITE});
        @(negedge clk_pix);
        check("bar_yellow", {8'd0, rgb}, {8'd0, C_YELLOW});
        wait_pix("bar2", 8, 5);
        check("bar_cyan", {8'd0, rgb}, {8'd0, C_CYAN});
        wait_pix("bar5", 20, 5);
        check("bar_red", {8'd0, rgb}, {8'd0, C_RED});
        wait_pix("bar6", 24, 5);
        check("bar_blue", {8'd0, rgb}, {8'd0, C_BLUE});
        wait_pix("bar7", 31, 5);
        check("bar_black", {8'd0, rgb}, {8'd0, C_BLACK});
        wait_pix("barsat", 35, 5);
        check("bar_saturated", {8'd0, rgb}, {8'd0, C_BLACK});
        wait_pix("blank_h", 40, 5);
        check("blank_h_de", {31'd0, de}, 32'd0);
        check("blank_h_rgb", {8'd0, rgb}, 32'd0);
        wait_pix("blank_v", 0, 26);
        check("blank_v_rgb", {8'd0, rgb}, 32'd0);

        // Mode change mid-frame does not tear
        mode = 2'd0;
        wait_frame("t5a");
        wait_pix("mid", 0, 10);
        mode = 2'd2;
        wait_pix("mid_sq", 8, 12);
        check("tear_sq_in", {8'd0, rgb}, {8'd0, C_WHITE});
        wait_pix("mid_bg", 7, 13);
        check("tear_sq_out", {8'd0, rgb}, {8'd0, C_BG});
        wait_frame("t5b");
        @(negedge clk_pix);
        check("chk_0_0", {8'd0, rgb}, {8'd0, C_BLACK});
        wait_pix("chk40", 4, 0);
        check("chk_4_0", {8'd0, rgb}, {8'd0, C_WHITE});
        wait_pix("chk80", 8, 0);
        check("chk_8_0", {8'd0, rgb}, {8'd0, C_BLACK});
        wait_pix("chk04", 0, 4);
        check("chk_0_4", {8'd0, rgb}, {8'd0, C_WHITE});
        wait_pix("chk44", 4, 4);
        check("chk_4_4", {8'd0, rgb}, {8'd0, C_BLACK});

        // Bouncing square: x in 0..16, y in 0..4
        mode = 2'd3;
        wait_frame("t4");
        k = frames + 1;
        while (k <= 20) begin
            found = 1'b0; fx = -1; fy = -1; cnt = 0;
            do begin
                @(negedge clk_pix);
                cnt++;
                if (!found && de && rgb == C_WHITE) begin
                    found = 1'b1;
                    fx = int'(sx);
                    fy = int'(sy);
                end
            end while (frame !== 1'b1 && cnt < 3000);
            check($sformatf("bounce_found_k%0d", k), {31'd0, found}, 32'd1);
            check($sformatf("bounce_x_k%0d", k), 32'(fx), 32'(bounce_pos(k, 16)));
            check($sformatf("bounce_y_k%0d", k), 32'(fy), 32'(bounce_pos(k, 4)));
            if (k == 12) check("bounce_y_top", 32'(fy), 32'd4);
            if (k == 13) check("bounce_y_back", 32'(fy), 32'd3);
            if (k == 16) check("bounce_x_edge", 32'(fx), 32'd16);
            if (k == 17) check("bounce_x_back", 32'(fx), 32'd15);
            k++;
        end

        // Asynchronous reset mid-line
        wait_pix("t6", 10, 3);
        #2;
        rst_pix = 1'b1;
        #1;
        check("arst_sx", {26'd0, sx}, 32'd0);
        check("arst_sy", {26'd0, sy}, 32'd0);
        check("arst_de", {31'd0, de}, 32'd0);
        check("arst_rgb", {8'd0, rgb}, 32'd0);
        check("arst_hsync", {31'd0, hsync}, 32'd1);
        check("arst_vsync", {31'd0, vsync}, 32'd1);
        check("arst_frame", {31'd0, frame}, 32'd0);
        @(negedge clk_pix);
        rst_pix = 1'b0;
        cnt = 0;
        do begin
            @(negedge clk_pix);
            cnt++;
        end while (frame !== 1'b1 && cnt < 3000);
        check("arst_frame_period", 32'(cnt), 32'd1232);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
